// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester UART transmitter with a round-robin scheduler.
// Frame = start bit, 8 data bits LSB first, [even parity bit], stop bit, with
// each bit held for CLKS_PER_BIT clocks. All outputs are registered.
// Optional feature macro: UART_TX_SCHED_PARITY_EN (adds the even-parity bit).
// A new grant is taken either from IDLE or on the very edge STOP completes,
// so frames can run back-to-back with no idle gap.
module uart_tx_sched #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       out,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_SCHED_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } state_t;
`endif

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    bit_idx_reg;
   logic [7:0]    data_reg;
   logic          out_reg;
   logic          busy_reg;
   logic          ack0_reg;
   logic          ack1_reg;
   // Requester granted most recently; reset value 1 makes requester 0 win the first tie.
   logic          last_reg;

   logic [1:0]    req_vec;
   logic [1:0]    grant_vec;
   logic [7:0]    grant_data;
   logic          stop_done;
   logic          launch;

   assign req_vec = {req1, req0};

   // Per-lane round-robin decision: a lane wins if it requests and either the
   // other lane is quiet or the other lane was the one granted last time.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      localparam logic LANE = 1'(gi);
      assign grant_vec[gi] = req_vec[gi] & (~req_vec[1-gi] | (last_reg != LANE));
   end

   assign grant_data = grant_vec[1] ? data1 : data0;
   assign stop_done  = (state_reg == STOP) && (cnt_reg == CNT_MAX);
   assign launch     = ((state_reg == IDLE) || stop_done) && (|req_vec);

   // Frame sequencer: grant/latch, bit timing, and registered line/busy/ack outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         data_reg    <= '0;
         out_reg     <= 1'b1;
         busy_reg    <= 1'b0;
         ack0_reg    <= 1'b0;
         ack1_reg    <= 1'b0;
         last_reg    <= 1'b1;
      end else begin
         ack0_reg <= 1'b0;
         ack1_reg <= 1'b0;
         if (launch) begin
            state_reg   <= START;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            data_reg    <= grant_data;
            out_reg     <= 1'b0;
            busy_reg    <= 1'b1;
            ack0_reg    <= grant_vec[0];
            ack1_reg    <= grant_vec[1];
            last_reg    <= grant_vec[1];
         end else begin
            case (state_reg)
               IDLE: begin
                  out_reg  <= 1'b1;
                  busy_reg <= 1'b0;
                  cnt_reg  <= '0;
               end
               START: begin
                  if (cnt_reg == CNT_MAX) begin
                     cnt_reg     <= '0;
                     bit_idx_reg <= '0;
                     state_reg   <= DATA;
                     out_reg     <= data_reg[0];
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
               DATA: begin
                  if (cnt_reg == CNT_MAX) begin
                     cnt_reg <= '0;
                     if (bit_idx_reg == 3'd7) begin
                        bit_idx_reg <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
                        state_reg   <= PARITY;
                        out_reg     <= ^data_reg;
`else
                        state_reg   <= STOP;
                        out_reg     <= 1'b1;
`endif
                     end else begin
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        out_reg     <= data_reg[bit_idx_reg + 3'd1];
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
`ifdef UART_TX_SCHED_PARITY_EN
               PARITY: begin
                  if (cnt_reg == CNT_MAX) begin
                     cnt_reg   <= '0;
                     state_reg <= STOP;
                     out_reg   <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
`endif
               STOP: begin
                  if (cnt_reg == CNT_MAX) begin
                     cnt_reg   <= '0;
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                     out_reg   <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
                  out_reg   <= 1'b1;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign out  = out_reg;
   assign busy = busy_reg;
   assign ack0 = ack0_reg;
   assign ack1 = ack1_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: table of single-frame vectors plus hand-written
// sequences for back-to-back ties, fairness, mid-frame reset and idle line.
// Honours UART_TX_SCHED_PARITY_EN for the expected frame shape and length.
module tb_uart_tx_sched;

   localparam int CPB = 16;
`ifdef UART_TX_SCHED_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [7:0] data0, data1;
   logic       ack0, ack1;
   logic       out, busy;

   int errors = 0;
   int checks = 0;

   uart_tx_sched #(.CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .rst  (rst),
      .req0 (req0),
      .data0(data0),
      .ack0 (ack0),
      .req1 (req1),
      .data1(data1),
      .ack1 (ack1),
      .out  (out),
      .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r0;
      logic       r1;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       e0;
      logic       e1;
      logic [7:0] eb;
   } vec_t;

   vec_t vt [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_SCHED_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   // Wait (bounded) for an ack; returns at the negedge where it is visible.
   task automatic wait_ack(output logic got, output logic a0, output logic a1);
      got = 1'b0; a0 = 1'b0; a1 = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ack0 | ack1) begin
            got = 1'b1; a0 = ack0; a1 = ack1;
            return;
         end
      end
   endtask

   // Called at the negedge where ack is seen (k=0); samples one frame.
   task automatic run_frame(input string tag, input logic [7:0] eb);
      logic [NB-1:0] cap;
      int blen;
      int extra;
      cap = '0; blen = 0; extra = 0;
      for (int k = 0; k < FL + 20; k++) begin
         if (k > 0) @(negedge clk);
         if (!busy) break;
         blen++;
         if (k > 0 && (ack0 | ack1)) extra++;
         if ((k % CPB) == CPB / 2 && (k / CPB) < NB) cap[k / CPB] = out;
      end
      check({tag, " frame"}, 64'(cap), 64'(frame_of(eb)));
      check({tag, " busy_len"}, 64'(blen), 64'(FL));
      check({tag, " extra_ack"}, 64'(extra), 64'd0);
      check({tag, " idle_line"}, 64'(out), 64'd1);
      $display("%s: byte=%02h frame=%0h busy_len=%0d", tag, eb, cap, blen);
   endtask

   initial begin
      logic got, a0, a1;
      logic [3*NB-1:0] cap3;
      logic [2*NB-1:0] cap2;
      int gaps;
      int bad;

      vt[0] = '{r0:1, r1:1, d0:8'hA5, d1:8'h3C, e0:1, e1:0, eb:8'hA5};
      vt[1] = '{r0:1, r1:1, d0:8'hA5, d1:8'h3C, e0:0, e1:1, eb:8'h3C};
      vt[2] = '{r0:1, r1:0, d0:8'h55, d1:8'h00, e0:1, e1:0, eb:8'h55};
      vt[3] = '{r0:1, r1:0, d0:8'h07, d1:8'h00, e0:1, e1:0, eb:8'h07};
      vt[4] = '{r0:1, r1:1, d0:8'h55, d1:8'hAA, e0:0, e1:1, eb:8'hAA};
      vt[5] = '{r0:0, r1:1, d0:8'h00, d1:8'h81, e0:0, e1:1, eb:8'h81};
      vt[6] = '{r0:1, r1:1, d0:8'h12, d1:8'h34, e0:1, e1:0, eb:8'h12};
      vt[7] = '{r0:0, r1:1, d0:8'h00, d1:8'h4E, e0:0, e1:1, eb:8'h4E};

      rst = 1'b1; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
      #2 rst = 1'b0;
      #1;
      check("reset out", 64'(out), 64'd1);
      check("reset busy", 64'(busy), 64'd0);
      check("reset ack0", 64'(ack0), 64'd0);
      check("reset ack1", 64'(ack1), 64'd0);
      $display("reset: out=%b busy=%b ack0=%b ack1=%b", out, busy, ack0, ack1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven single frames; data is scrambled right after the ack.
      for (int v = 0; v < 8; v++) begin
         req0 = vt[v].r0; req1 = vt[v].r1; data0 = vt[v].d0; data1 = vt[v].d1;
         wait_ack(got, a0, a1);
         check($sformatf("vec%0d ack_seen", v), 64'(got), 64'd1);
         check($sformatf("vec%0d acks", v), 64'({a0, a1}), 64'({vt[v].e0, vt[v].e1}));
         req0 = 0; req1 = 0; data0 = 8'h00; data1 = 8'h00;
         if (got) run_frame($sformatf("vec%0d", v), vt[v].eb);
         repeat (2) @(negedge clk);
      end

      // Reset in the middle of data bit 4 of 8'hFF.
      req0 = 1; data0 = 8'hFF;
      wait_ack(got, a0, a1);
      check("rstmid ack0", 64'(a0), 64'd1);
      req0 = 0;
      repeat (88) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid out", 64'(out), 64'd1);
      check("rstmid busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) bad++;
      end
      check("rstmid idle_after", 64'(bad), 64'd0);
      $display("rstmid: out=%b busy=%b bad_cycles=%0d", out, busy, bad);

      // Held tie after reset: A5, 3C, A5 back-to-back with alternating acks.
      req0 = 1; req1 = 1; data0 = 8'hA5; data1 = 8'h3C;
      wait_ack(got, a0, a1);
      check("tie first ack", 64'({a0, a1}), 64'b10);
      cap3 = '0; gaps = 0;
      for (int k = 0; k < 3 * FL; k++) begin
         if (k > 0) @(negedge clk);
         if (!busy) gaps++;
         if (k == FL) check("tie second ack", 64'({ack0, ack1}), 64'b01);
         if (k == 2 * FL) check("tie third ack", 64'({ack0, ack1}), 64'b10);
         if (k == 2 * FL + 5) begin req0 = 0; req1 = 0; end
         if ((k % CPB) == CPB / 2) cap3[k / CPB] = out;
      end
      check("tie gaps", 64'(gaps), 64'd0);
      check("tie frames", 64'(cap3), 64'({frame_of(8'hA5), frame_of(8'h3C), frame_of(8'hA5)}));
      @(negedge clk);
      check("tie end busy", 64'(busy), 64'd0);
      $display("tie: frames=%0h gaps=%0d", cap3, gaps);
      repeat (2) @(negedge clk);

      // Fairness: req1 alone, req0 rises mid-frame; requester 0 must win next.
      req1 = 1; data1 = 8'h3C;
      wait_ack(got, a0, a1);
      check("fair first ack", 64'({a0, a1}), 64'b01);
      cap2 = '0; gaps = 0;
      for (int k = 0; k < 2 * FL; k++) begin
         if (k > 0) @(negedge clk);
         if (!busy) gaps++;
         if (k == 40) begin req0 = 1; data0 = 8'h5A; end
         if (k == FL) begin
            check("fair second ack", 64'({ack0, ack1}), 64'b10);
            req0 = 0; req1 = 0;
         end
         if ((k % CPB) == CPB / 2) cap2[k / CPB] = out;
      end
      check("fair gaps", 64'(gaps), 64'd0);
      check("fair frames", 64'(cap2), 64'({frame_of(8'h5A), frame_of(8'h3C)}));
      @(negedge clk);
      check("fair end busy", 64'(busy), 64'd0);
      $display("fair: frames=%0h gaps=%0d", cap2, gaps);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
